// File: rtl/fetch_stage_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes, FSM states,
// the decoded-fetch bundle and small per-icode decode helpers.
package fetch_stage_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  stat;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        hlt;
        logic        imem_err;
        logic        instr_inv;
    } fetch_out_t;

    function automatic logic need_regids(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            default:                need_regids = 1'b0;
        endcase
    endfunction

    function automatic logic need_valc(input logic [3:0] icode);
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: need_valc = 1'b1;
            default:                                     need_valc = 1'b0;
        endcase
    endfunction

    // Legal function codes per instruction class; icodes above POPQ never match.
    function automatic logic ifun_ok(input logic [3:0] icode, input logic [3:0] ifun);
        case (icode)
            I_OPQ:            ifun_ok = (ifun <= 4'd3);
            I_JXX, I_RRMOVQ:  ifun_ok = (ifun <= 4'd6);
            I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ: ifun_ok = (ifun == 4'd0);
            default:          ifun_ok = 1'b0;
        endcase
    endfunction

    // Nop bubble presented while halted; valP reports the address being held.
    function automatic fetch_out_t bubble(input logic [63:0] pc);
        fetch_out_t b;
        b.icode     = I_NOP;
        b.ifun      = 4'h0;
        b.ra        = RNONE;
        b.rb        = RNONE;
        b.stat      = STAT_AOK;
        b.valc      = 64'd0;
        b.valp      = pc;
        b.hlt       = 1'b0;
        b.imem_err  = 1'b0;
        b.instr_inv = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_align.sv
// Combinational instruction split: field extraction, length, validity and
// status for the 10 bytes presented at the fetch address.
module fetch_align
    import fetch_stage_pkg::*;
(
    input  logic [63:0] pc_i,
    input  logic [79:0] data_i,
    input  logic        err_i,
    output fetch_out_t  dec_o
);

    logic [3:0] icode_s;
    logic [3:0] ifun_s;
    logic       inv_s;
    logic       regids_s;
    logic       valc_n_s;
    logic       hlt_s;

    assign icode_s = data_i[7:4];
    assign ifun_s  = data_i[3:0];

    // Invalid encodings collapse to a 1-byte instruction with no fields.
    assign inv_s    = (icode_s > I_POPQ) || !ifun_ok(icode_s, ifun_s);
    assign regids_s = !inv_s && need_regids(icode_s);
    assign valc_n_s = !inv_s && need_valc(icode_s);
    assign hlt_s    = (icode_s == I_HALT) && !inv_s;

    // Field extraction and status priority: address error beats halt beats invalid.
    always_comb begin
        dec_o.icode     = icode_s;
        dec_o.ifun      = ifun_s;
        dec_o.hlt       = hlt_s;
        dec_o.imem_err  = err_i;
        dec_o.instr_inv = inv_s;

        if (regids_s) begin
            dec_o.ra = data_i[15:12];
            dec_o.rb = data_i[11:8];
        end else begin
            dec_o.ra = RNONE;
            dec_o.rb = RNONE;
        end

        if (!valc_n_s) begin
            dec_o.valc = 64'd0;
        end else if (regids_s) begin
            dec_o.valc = data_i[79:16];
        end else begin
            dec_o.valc = data_i[71:8];
        end

        dec_o.valp = pc_i + 64'd1 + {63'd0, regids_s} + (valc_n_s ? 64'd8 : 64'd0);

        if (err_i) begin
            dec_o.stat = STAT_ADR;
        end else if (hlt_s) begin
            dec_o.stat = STAT_HLT;
        end else if (inv_s) begin
            dec_o.stat = STAT_INS;
        end else begin
            dec_o.stat = STAT_AOK;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, predicted-PC register and RUN/HALTED control.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        F_stall,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_data,
    input  logic        imem_err,
    output logic [3:0]  f_icode,
    output logic [3:0]  f_ifun,
    output logic [3:0]  f_stat,
    output logic [3:0]  f_rA,
    output logic [3:0]  f_rB,
    output logic [63:0] f_valC,
    output logic [63:0] f_valP,
    output logic        f_hlt,
    output logic        f_imem_err,
    output logic        f_instr_inv
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pred_pc_q, pred_pc_d;

    logic         mispredict_s;
    logic         ret_s;
    logic         redirect_s;
    logic [63:0]  pc_s;
    logic [63:0]  pred_next_s;
    fetch_out_t   dec_s;
    fetch_out_t   out_s;

    assign mispredict_s = (M_icode == I_JXX) && !M_Cnd;
    assign ret_s        = (W_icode == I_RET);
    assign redirect_s   = mispredict_s || ret_s;

    // PC select: not-taken branch correction beats ret target beats prediction.
    always_comb begin
        if (mispredict_s) begin
            pc_s = M_valA;
        end else if (ret_s) begin
            pc_s = W_valM;
        end else begin
            pc_s = pred_pc_q;
        end
    end

    assign imem_addr = pc_s;

    fetch_align u_align (
        .pc_i   (pc_s),
        .data_i (imem_data),
        .err_i  (imem_err),
        .dec_o  (dec_s)
    );

    assign pred_next_s = ((dec_s.icode == I_JXX) || (dec_s.icode == I_CALL)) ? dec_s.valc
                                                                             : dec_s.valp;

    // A redirect revives fetch even while halted; otherwise HALTED emits a bubble.
    always_comb begin
        if ((state_q == ST_RUN) || redirect_s) begin
            out_s = dec_s;
        end else begin
            out_s = bubble(pc_s);
        end
    end

    assign f_icode     = out_s.icode;
    assign f_ifun      = out_s.ifun;
    assign f_stat      = out_s.stat;
    assign f_rA        = out_s.ra;
    assign f_rB        = out_s.rb;
    assign f_valC      = out_s.valc;
    assign f_valP      = out_s.valp;
    assign f_hlt       = out_s.hlt;
    assign f_imem_err  = out_s.imem_err;
    assign f_instr_inv = out_s.instr_inv;

    // Next state and predicted PC; a stall always freezes predPC.
    always_comb begin
        state_d   = state_q;
        pred_pc_d = pred_pc_q;
        case (state_q)
            ST_RUN: begin
                if (!F_stall) begin
                    pred_pc_d = pred_next_s;
                    if (dec_s.stat != STAT_AOK) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (redirect_s) begin
                    state_d = ST_RUN;
                    if (!F_stall) begin
                        pred_pc_d = pred_next_s;
                    end else begin
                        pred_pc_d = pred_pc_q;
                    end
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d   = ST_RUN;
                pred_pc_d = 64'd0;
            end
        endcase
    end

    // State and predicted-PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pred_pc_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            pred_pc_q <= pred_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating activity counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (!F_stall && (state_q == ST_RUN) && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                fetch_cnt_q <= fetch_cnt_q;
            end
            if (F_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; covers FETCH_PERF_CNT_EN when defined.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        F_stall;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_err;
    logic [3:0]  f_icode, f_ifun, f_stat, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic        f_hlt, f_imem_err, f_instr_inv;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [79:0] D_NOP    = 80'h10;
    localparam logic [79:0] D_HALT   = 80'h00;
    localparam logic [79:0] D_IRMOV  = {56'h0, 8'h10, 8'hF0, 8'h30};
    localparam logic [79:0] D_JMP20  = {8'h00, 64'h20, 8'h70};
    localparam logic [79:0] D_JMP100 = {8'h00, 64'h100, 8'h70};

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .F_stall     (F_stall),
        .M_icode     (M_icode),
        .M_Cnd       (M_Cnd),
        .M_valA      (M_valA),
        .W_icode     (W_icode),
        .W_valM      (W_valM),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_err    (imem_err),
        .f_icode     (f_icode),
        .f_ifun      (f_ifun),
        .f_stat      (f_stat),
        .f_rA        (f_rA),
        .f_rB        (f_rB),
        .f_valC      (f_valC),
        .f_valP      (f_valP),
        .f_hlt       (f_hlt),
        .f_imem_err  (f_imem_err),
        .f_instr_inv (f_instr_inv)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; F_stall = 1'b0; M_icode = 4'h0; M_Cnd = 1'b1; M_valA = 64'd0;
        W_icode = 4'h0; W_valM = 64'd0; imem_data = D_NOP; imem_err = 1'b0;
        #1;
        checks++; if (imem_addr !== 64'd0) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, 64'd0); end
        checks++; if (f_valP !== 64'd1) begin errors++; $display("FAIL reset_valp got %h exp %h", f_valP, 64'd1); end
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_irmovq();
        imem_data = D_IRMOV;
        #1;
        checks++; if (f_icode !== 4'h3) begin errors++; $display("FAIL irmov_icode got %h exp %h", f_icode, 4'h3); end
        checks++; if (f_rA !== 4'hF) begin errors++; $display("FAIL irmov_ra got %h exp %h", f_rA, 4'hF); end
        checks++; if (f_rB !== 4'h0) begin errors++; $display("FAIL irmov_rb got %h exp %h", f_rB, 4'h0); end
        checks++; if (f_valC !== 64'h10) begin errors++; $display("FAIL irmov_valc got %h exp %h", f_valC, 64'h10); end
        checks++; if (f_valP !== 64'h0A) begin errors++; $display("FAIL irmov_valp got %h exp %h", f_valP, 64'h0A); end
        checks++; if (f_stat !== 4'd1) begin errors++; $display("FAIL irmov_stat got %h exp %h", f_stat, 4'd1); end
        tick();
        checks++; if (imem_addr !== 64'h0A) begin errors++; $display("FAIL irmov_predpc got %h exp %h", imem_addr, 64'h0A); end
    endtask

    task automatic test_jump_redirect();
        imem_data = D_JMP20;
        #1;
        checks++; if (f_valC !== 64'h20) begin errors++; $display("FAIL jmp_valc got %h exp %h", f_valC, 64'h20); end
        checks++; if (f_valP !== 64'h13) begin errors++; $display("FAIL jmp_valp got %h exp %h", f_valP, 64'h13); end
        tick();
        checks++; if (imem_addr !== 64'h20) begin errors++; $display("FAIL jmp_target got %h exp %h", imem_addr, 64'h20); end
        imem_data = D_JMP100;
        tick();
        checks++; if (imem_addr !== 64'h100) begin errors++; $display("FAIL jmp100_target got %h exp %h", imem_addr, 64'h100); end
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h29; W_icode = 4'h9; W_valM = 64'h40; imem_data = D_NOP;
        #1;
        checks++; if (imem_addr !== 64'h29) begin errors++; $display("FAIL mispredict_addr got %h exp %h", imem_addr, 64'h29); end
        checks++; if (f_valP !== 64'h2A) begin errors++; $display("FAIL mispredict_valp got %h exp %h", f_valP, 64'h2A); end
        M_Cnd = 1'b1;
        #1;
        checks++; if (imem_addr !== 64'h40) begin errors++; $display("FAIL ret_prio_addr got %h exp %h", imem_addr, 64'h40); end
        M_Cnd = 1'b0;
        tick();
        M_icode = 4'h0; W_icode = 4'h0;
        #1;
        checks++; if (imem_addr !== 64'h2A) begin errors++; $display("FAIL redirect_succ got %h exp %h", imem_addr, 64'h2A); end
    endtask

    task automatic test_redirect_stall();
        F_stall = 1'b1; M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h29; imem_data = D_IRMOV;
        #1;
        checks++; if (imem_addr !== 64'h29) begin errors++; $display("FAIL rdstall_addr got %h exp %h", imem_addr, 64'h29); end
        checks++; if (f_valP !== 64'h33) begin errors++; $display("FAIL rdstall_valp got %h exp %h", f_valP, 64'h33); end
        tick();
        M_icode = 4'h0;
        #1;
        checks++; if (imem_addr !== 64'h2A) begin errors++; $display("FAIL rdstall_held got %h exp %h", imem_addr, 64'h2A); end
    endtask

    task automatic test_decode();
        imem_data = 80'h64;
        #1;
        checks++; if (f_instr_inv !== 1'b1) begin errors++; $display("FAIL opq_inv got %h exp %h", f_instr_inv, 1'b1); end
        checks++; if (f_stat !== 4'd4) begin errors++; $display("FAIL opq_stat got %h exp %h", f_stat, 4'd4); end
        checks++; if (f_valP !== 64'h2B) begin errors++; $display("FAIL opq_len got %h exp %h", f_valP, 64'h2B); end
        checks++; if (f_rA !== 4'hF) begin errors++; $display("FAIL opq_ra got %h exp %h", f_rA, 4'hF); end
        imem_data = {64'h0, 8'h01, 8'h63};
        #1;
        checks++; if (f_instr_inv !== 1'b0) begin errors++; $display("FAIL xorq_inv got %h exp %h", f_instr_inv, 1'b0); end
        checks++; if ({f_rA, f_rB} !== 8'h01) begin errors++; $display("FAIL xorq_regs got %h exp %h", {f_rA, f_rB}, 8'h01); end
        checks++; if (f_valP !== 64'h2C) begin errors++; $display("FAIL xorq_valp got %h exp %h", f_valP, 64'h2C); end
        imem_data = {64'h1122334455667788, 8'h12, 8'h40};
        #1;
        checks++; if (f_valC !== 64'h1122334455667788) begin errors++; $display("FAIL rmmov_valc got %h exp %h", f_valC, 64'h1122334455667788); end
        checks++; if (f_valP !== 64'h34) begin errors++; $display("FAIL rmmov_valp got %h exp %h", f_valP, 64'h34); end
        checks++; if ({f_rA, f_rB} !== 8'h12) begin errors++; $display("FAIL rmmov_regs got %h exp %h", {f_rA, f_rB}, 8'h12); end
    endtask

    task automatic test_imem_err();
        imem_data = 80'hC0; imem_err = 1'b1;
        #1;
        checks++; if (f_stat !== 4'd3) begin errors++; $display("FAIL err_stat got %h exp %h", f_stat, 4'd3); end
        checks++; if (f_instr_inv !== 1'b1) begin errors++; $display("FAIL err_inv got %h exp %h", f_instr_inv, 1'b1); end
        checks++; if (f_imem_err !== 1'b1) begin errors++; $display("FAIL err_flag got %h exp %h", f_imem_err, 1'b1); end
        tick();
        checks++; if (imem_addr !== 64'h2A) begin errors++; $display("FAIL err_stall_pc got %h exp %h", imem_addr, 64'h2A); end
        checks++; if (f_icode !== 4'hC) begin errors++; $display("FAIL err_stays_run got %h exp %h", f_icode, 4'hC); end
        imem_err = 1'b0;
    endtask

    task automatic test_halt();
        F_stall = 1'b0; imem_data = D_HALT;
        #1;
        checks++; if (f_stat !== 4'd2) begin errors++; $display("FAIL halt_stat got %h exp %h", f_stat, 4'd2); end
        checks++; if (f_hlt !== 1'b1) begin errors++; $display("FAIL halt_flag got %h exp %h", f_hlt, 1'b1); end
        tick();
        imem_data = D_IRMOV;
        #1;
        checks++; if (f_icode !== 4'h1) begin errors++; $display("FAIL halted_icode got %h exp %h", f_icode, 4'h1); end
        checks++; if (f_stat !== 4'd1) begin errors++; $display("FAIL halted_stat got %h exp %h", f_stat, 4'd1); end
        checks++; if ({f_rA, f_rB} !== 8'hFF) begin errors++; $display("FAIL halted_regs got %h exp %h", {f_rA, f_rB}, 8'hFF); end
        checks++; if (f_valC !== 64'd0) begin errors++; $display("FAIL halted_valc got %h exp %h", f_valC, 64'd0); end
        checks++; if (f_valP !== 64'h2B) begin errors++; $display("FAIL halted_valp got %h exp %h", f_valP, 64'h2B); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_addr !== 64'h2B) begin errors++; $display("FAIL halted_hold%0d got %h exp %h", i, imem_addr, 64'h2B); end
            checks++; if (f_icode !== 4'h1) begin errors++; $display("FAIL halted_bubble%0d got %h exp %h", i, f_icode, 4'h1); end
        end
    endtask

    task automatic test_ret_exit();
        W_icode = 4'h9; W_valM = 64'h40;
        #1;
        checks++; if (imem_addr !== 64'h40) begin errors++; $display("FAIL retexit_addr got %h exp %h", imem_addr, 64'h40); end
        checks++; if (f_valP !== 64'h4A) begin errors++; $display("FAIL retexit_valp got %h exp %h", f_valP, 64'h4A); end
        tick();
        W_icode = 4'h0;
        #1;
        checks++; if (imem_addr !== 64'h4A) begin errors++; $display("FAIL retexit_succ got %h exp %h", imem_addr, 64'h4A); end
        checks++; if (f_icode !== 4'h3) begin errors++; $display("FAIL retexit_run got %h exp %h", f_icode, 4'h3); end
    endtask

    task automatic test_async_reset();
        imem_data = D_HALT;
        tick();
        checks++; if (f_icode !== 4'h1) begin errors++; $display("FAIL prereset_halted got %h exp %h", f_icode, 4'h1); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_addr !== 64'd0) begin errors++; $display("FAIL async_reset_pc got %h exp %h", imem_addr, 64'd0); end
        tick();
        rst_n = 1'b1; imem_data = D_IRMOV;
        #1;
        checks++; if (f_icode !== 4'h3) begin errors++; $display("FAIL postreset_run got %h exp %h", f_icode, 4'h3); end
        checks++; if (imem_addr !== 64'd0) begin errors++; $display("FAIL postreset_pc got %h exp %h", imem_addr, 64'd0); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        imem_data = D_NOP;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL fetch_cnt got %0d exp %0d", fetch_cnt, 32'd5); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stall_cnt0 got %0d exp %0d", stall_cnt, 32'd0); end
        F_stall = 1'b1;
        tick(); tick();
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, 32'd2); end
        checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL fetch_cnt_held got %0d exp %0d", fetch_cnt, 32'd5); end
        F_stall = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_irmovq();
        test_jump_redirect();
        test_redirect_stall();
        test_decode();
        test_imem_err();
        test_halt();
        test_ret_exit();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
